// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter and scoreboard for the register-file write port.
// WB_RR_EN defined selects round-robin arbitration; undefined gives fixed M priority.
module reg_wb_arbiter #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_ad,
  input  logic [DW-1:0]        a_d,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [AW-1:0]        m_ad,
  input  logic [DW-1:0]        m_d,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_ad,
  input  logic [AW-1:0]        ad_a,
  input  logic [AW-1:0]        ad_b,
  output logic                 haz_a,
  output logic                 haz_b,
  output logic                 we,
  output logic [AW-1:0]        wr_ad,
  output logic [DW-1:0]        d,
  output logic [(1<<AW)-1:0]   busy
);

  localparam int NREG = 1 << AW;

  logic            m_wins;
  logic [NREG-1:0] busy_nxt;

`ifdef WB_RR_EN
  // Pointer holds the last winner; reset as if A won so M is favoured first.
  logic last_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_a <= 1'b1;
    end else if (a_ready) begin
      last_a <= 1'b1;
    end else if (m_ready) begin
      last_a <= 1'b0;
    end
  end

  assign m_wins = last_a;
`else
  assign m_wins = 1'b1;
`endif

  // m_wins only matters on contention; a lone request is always granted.
  assign a_ready = a_valid && !(m_valid && m_wins);
  assign m_ready = m_valid && !(a_valid && !m_wins);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we    <= 1'b0;
      wr_ad <= '0;
      d     <= '0;
    end else if (a_ready) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      we    <= 1'b1;
      wr_ad <= a_ad;
      d     <= a_d;
    end else if (m_ready) begin
      we    <= 1'b1;
      wr_ad <= m_ad;
      d     <= m_d;
    end else begin
      we    <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns busy_nxt and no latch is inferred.
    busy_nxt = busy;
    if (we) begin
      busy_nxt[wr_ad] = 1'b0;
    end
    // Set after clear: a newer producer on the same register stays pending.
    if (iss_valid) begin
      busy_nxt[iss_ad] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign haz_a = busy[ad_a];
  assign haz_b = busy[ad_b];

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and scoreboard for the 16×32 register file. Two write-back sources compete for the single register-file write port: the ALU result path (A) and the load-return path (M, LW data). The block grants one source per cycle and drives the registered `we`/`wr_ad`/`d` into the register file. It also tracks which registers have a write outstanding, so the decode stage can stall on read-after-write hazards for `ad_a`/`ad_b`.

## Interface
Parameters:
- `AW`, 4: register address width (16 registers)
- `DW`, 32: data width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  ALU write-back request
- `a_ready`  out  1  ALU request granted this cycle (combinational)
- `a_ad`  in  AW  ALU destination register
- `a_d`  in  DW  ALU result
- `m_valid`  in  1  load write-back request
- `m_ready`  out  1  load request granted this cycle (combinational)
- `m_ad`  in  AW  load destination register
- `m_d`  in  DW  load data
- `iss_valid`  in  1  decode issues an instruction with a destination
- `iss_ad`  in  AW  destination of the issued instruction
- `ad_a`, `ad_b`  in  AW  source registers being read by decode
- `haz_a`, `haz_b`  out  1  write to `ad_a`/`ad_b` pending (combinational)
- `we`  out  1  register-file write enable (registered)
- `wr_ad`  out  AW  register-file write address (registered)
- `d`  out  DW  register-file write data (registered)
- `busy`  out  16  scoreboard bitmap, bit i = write to register i outstanding

## Operation
- A transfer on a port occurs at a rising edge where `x_valid && x_ready`. At most one of `a_ready`/`m_ready` is high in any cycle.
- Only one valid: that source is granted immediately.
- Both valid: the arbitration policy applies (see Configuration). The loser's `ready` stays low. The loser must hold `valid`, `ad` and `d` stable until granted.
- Neither valid: both `ready` are 0, and `we` goes 0 the next cycle.
- On a transfer, `we`←1, `wr_ad`←granted `ad`, `d`←granted data. With no transfer, `we`←0 and `wr_ad`/`d` hold their last values.
- Scoreboard update per edge:
  - `iss_valid` sets `busy[iss_ad]`.
  - A committed write (`we`=1 this cycle) clears `busy[wr_ad]`.
  - When the same register is both set and cleared on one edge, set wins: the newer producer stays pending.
- `haz_a = busy[ad_a]` and `haz_b = busy[ad_b]`.
  - The hazard stays high through the cycle in which `we` is asserted for that register.
  - It falls the cycle after, when the register-file read returns the new value.
- Decode is required not to issue two outstanding writes to the same register. Behaviour in that case: the first commit clears the bit early; this is not detected.

## Timing
- Reset (async assert, sync deassert handled upstream) clears all state:
  - outputs: `we`=0, `wr_ad`=0, `d`=0, `busy`=0
  - round-robin pointer favours M first
  - `a_ready`/`m_ready` follow their inputs combinationally and may be high during reset
  - nothing transfers while `rst_n`=0
- Latency:
  - request valid at cycle N with grant → `we` high in cycle N+1 → register-file array updated at the end of N+1
  - `busy` cleared from cycle N+2
- Throughput: one write per cycle sustained. With both sources saturated under round-robin, each gets every other cycle.
- Reset mid-operation: the in-flight write (`we`=1) is dropped and all pending scoreboard bits are lost. Upstream is reset together with this block.

## Configuration
- `WB_RR_EN` defined: round-robin arbitration. A 1-bit pointer records the last winner. On contention the other source wins, and the pointer updates on every transfer.
- `WB_RR_EN` undefined: fixed priority, M always wins on contention. The pointer register is not built. The ALU can starve under continuous load returns, which is acceptable because loads are sparse.

## Test plan
- Reset: assert `rst_n`=0 mid-stream → `we`=0, `busy`=16'h0000, `wr_ad`=0, `d`=0 immediately; after release, idle inputs keep `we`=0.
- Single source: `a_valid`=1, `a_ad`=3, `a_d`=32'hDEADBEEF → `a_ready`=1 same cycle; next cycle `we`=1, `wr_ad`=3, `d`=32'hDEADBEEF.
- Contention: `a_valid`=`m_valid`=1 for 4 cycles (A→r1, M→r2, held until granted):
  - `WB_RR_EN` defined: grants M, A, M, A.
  - `WB_RR_EN` undefined: grants M every cycle and `a_ready`=0 throughout.
- Scoreboard: `iss_valid`, `iss_ad`=5, then A writes r5 two cycles later → `haz_a`=1 while `ad_a`=5 up to and including the `we` cycle; `busy[5]`=0 the cycle after.
- Same-edge set/clear: commit to r7 (`we`=1, `wr_ad`=7) on the same edge as `iss_valid`, `iss_ad`=7 → `busy[7]` remains 1.
- Back-to-back: M valid for 3 consecutive cycles to r8, r9, r10 → `we`=1 for 3 consecutive cycles with matching `wr_ad`/`d`, no bubbles.
